ysyx_22040125_lut_mux_pipe: RTL
===============================

// Module: ysyx_22040125_lut_mux_pipe
// PURPOSE
//  Run-time programmable key->data lookup mux with a registered, valid/ready-handshaked result.
//  Successor to the static key-mux LUT: entries are written at run time and carry valid bits.
//  Adds hit/multi-hit flags, a default value and one pipeline stage.
//  Used for decode/CSR-style lookups where timing needs a register between lookup and consumer.
// PARAMETERS
//  NR_KEY      4   number of table entries (>=1); IDX_W = (NR_KEY>1) ? $clog2(NR_KEY) : 1
//  KEY_LEN     7   key width in bits
//  DATA_LEN    32  data width in bits
//  HAS_DEFAULT 1   1: a miss returns DEFAULT_VAL; 0: a miss returns 0
//  DEFAULT_VAL 0   DATA_LEN-bit value returned on a miss when HAS_DEFAULT=1
// PORTS
//  clk       in   1         single clock, rising edge
//  rst       in   1         asynchronous, active-high reset
//  clr       in   1         synchronous clear of all entry valid bits
//  wr_en     in   1         write entry wr_idx
//  wr_idx    in   IDX_W     entry index; wr_idx>=NR_KEY ignored
//  wr_key    in   KEY_LEN   key to store
//  wr_data   in   DATA_LEN  data to store
//  in_valid  in   1         lookup request valid
//  in_ready  out  1         lookup request accepted when in_valid&in_ready
//  in_key    in   KEY_LEN   lookup key
//  out_valid out  1         result valid
//  out_ready in   1         consumer accepts result
//  out_data  out  DATA_LEN  looked-up data
//  out_hit   out  1         >=1 valid entry matched
//  out_multi out  1         >=2 valid entries matched
// BEHAVIOUR
//  Reset (async): all entry valid bits=0, out_valid=0, out_data=0, out_hit=0, out_multi=0.
//  Table: on posedge, clr=1 clears every valid bit. clr has priority over wr_en in the same cycle.
//   Otherwise wr_en with wr_idx<NR_KEY stores key and data and sets the valid bit.
//   Key/data storage is not reset; only the valid bits are reset.
//  Match: entry i matches iff valid[i] && key[i]==in_key; invalid entries never match.
//  Lookup reads the pre-edge table: a write or clr in the same cycle is visible from the next request.
//  Handshake: in_ready = !out_valid || out_ready (combinational; no path from in_valid).
//   On accept, the result registers next edge: out_valid=1, latency exactly 1 cycle.
//   If out_valid && out_ready and no accept, out_valid falls to 0 next edge.
//   While out_valid && !out_ready, out_data, out_hit and out_multi hold stable.
//   Back-to-back accepts give one result per cycle with no bubble.
//  Miss: out_data = HAS_DEFAULT ? DEFAULT_VAL : 0; out_hit=0; out_multi=0.
//  Hit merge: see CONFIGURATION. out_multi is computed independent of merge mode.
//  Reset mid-transfer: the pending result is dropped (out_valid=0); the table is invalidated.
// CONFIGURATION
//  YSYX_22040125_LUT_PRIO_EN defined: priority select; the lowest matching index supplies out_data.
//  YSYX_22040125_LUT_PRIO_EN undefined: out_data = bitwise OR of the data of all matching entries.
//  Single-hit results are identical in both modes.
// TESTING
//  1. After rst, lookup key 7'h13 (HAS_DEFAULT=1, DEFAULT_VAL=32'hDEAD) -> next cycle:
//     out_valid=1, out_data=32'hDEAD, out_hit=0.
//  2. Write idx0 {7'h13, 32'h0000_00F0}; next cycle lookup 7'h13 -> out_data=32'hF0,
//     out_hit=1, out_multi=0, 1-cycle latency.
//  3. Write idx1 {7'h13, 32'h0000_000F}; lookup 7'h13 -> out_multi=1;
//     out_data=32'hF0 with PRIO_EN, 32'hFF without.
//  4. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable;
//     then out_ready=1 for 4 cycles with a new key each cycle -> 4 results on consecutive cycles.
//  5. Same cycle: clr=1, wr_en=1 idx2 key 7'h05, plus lookup 7'h13 accepted -> result hits (old table);
//     next lookup of 7'h05 misses (clr wins).
//  6. Assert rst while out_valid=1 && out_ready=0 -> out_valid=0 immediately;
//     after release, lookup 7'h13 misses.

Source files
------------

// File: rtl/ysyx_22040125_lut_mux_pipe.sv
// ---------------------------------------------------------------------------
// ysyx_22040125_lut_mux_pipe
//
// Run-time programmable key->data lookup table. A request is matched against
// every valid entry combinationally. The merged result is then registered
// behind a single valid/ready output stage.
//
// Build option:
//   YSYX_22040125_LUT_PRIO_EN  defined   -> the lowest matching index supplies out_data
//                              undefined -> out_data is the OR of all matching entries
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   clr                 synchronous clear of every entry valid bit (beats wr_en)
//   wr_en/wr_idx/       write one entry; an index >= NR_KEY is ignored
//   wr_key/wr_data
//   in_valid/in_ready/  lookup request handshake and key
//   in_key
//   out_valid/out_ready result handshake
//   out_data            looked-up data (default value on a miss)
//   out_hit/out_multi   at least one / at least two valid entries matched
// ---------------------------------------------------------------------------
module ysyx_22040125_lut_mux_pipe #(
  parameter int                  NR_KEY      = 4,
  parameter int                  KEY_LEN     = 7,
  parameter int                  DATA_LEN    = 32,
  parameter int                  HAS_DEFAULT = 1,
  parameter logic [DATA_LEN-1:0] DEFAULT_VAL = '0,
  localparam int                 IDX_W       = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_LEN-1:0]  in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_hit,
  output logic                out_multi
);

  logic [NR_KEY-1:0]   valid_q;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];

  logic [NR_KEY-1:0]   match;
  logic                lk_hit;
  logic                lk_multi;
  logic [DATA_LEN-1:0] lk_data;
  logic                accept;

  // -------------------------------------------------------------------------
  // Table storage
  // -------------------------------------------------------------------------
  // Indices at or above NR_KEY never equal a loop index, so they are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_W'(i)) valid_q[i] <= 1'b1;
      end
    end
  end

  // NOTE: key/data arrays are deliberately not reset. The valid bits gate
  // every use of them, and leaving them unreset lets them map onto plain
  // flops or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          key_q[i]  <= wr_key;
          data_q[i] <= wr_data;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lookup (reads the pre-edge table)
  // -------------------------------------------------------------------------
  // NOTE: combinational blocks give every output a default first and use
  // blocking assignments. This prevents latches, and it lets the loops
  // accumulate within a single evaluation.
  always_comb begin
    match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = valid_q[i] && (key_q[i] == in_key);
    end
  end

  always_comb begin
    lk_hit   = 1'b0;
    lk_multi = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        if (lk_hit) lk_multi = 1'b1;
        lk_hit = 1'b1;
      end
    end
  end

  always_comb begin
    lk_data = '0;
`ifdef YSYX_22040125_LUT_PRIO_EN
    // Walk from the top down so that the lowest matching index is written last.
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (match[i]) lk_data = data_q[i];
    end
`else
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) lk_data = lk_data | data_q[i];
    end
`endif
    if (!lk_hit) lk_data = (HAS_DEFAULT != 0) ? DEFAULT_VAL : '0;
  end

  // -------------------------------------------------------------------------
  // Output register with valid/ready
  // -------------------------------------------------------------------------
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_hit   <= 1'b0;
      out_multi <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lk_data;
      out_hit   <= lk_hit;
      out_multi <= lk_multi;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
